// File: rtl/uart_rx.sv
// uart_rx: oversampling 8N1 receiver with a small byte FIFO, exposed as a
// memory-mapped slave (RXDATA / STATUS / CTRL) and a level interrupt.
module uart_rx #(
    parameter int          CLK_FREQ   = 50_000_000,
    parameter int          BAUD_RATE  = 115200,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] BASE_ADDR  = 32'h2000_0200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] write_data,
    input  logic        write_enable,
    input  logic        read_enable,
    output logic [31:0] read_data,
    output logic        rx_valid,
    output logic        rx_interrupt,
    input  logic        rx
);
    localparam int CPB   = CLK_FREQ / BAUD_RATE;
    localparam int CNT_W = $clog2(CPB);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CPB - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CPB / 2 - 1);
    localparam logic [4:0]       DEPTH_C  = 5'(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic             rx_q1, rx_s;
    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       idx;
    logic [7:0]       shreg;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [4:0]       count, count_n;
    logic             overrun, frame_err, irq_en;
    logic             overrun_n, frame_err_n, irq_en_n;

    logic       stop_tick, push_req, ferr_set, hit, not_empty, full;
    logic       wr_ctrl, pop, flush, do_push, do_pop, ovr_set;
    logic [3:0] off;
    logic       unused_bits;

    assign unused_bits = &{1'b0, write_data[31:4]};

    // Two-flop synchroniser; idles high so reset never looks like a start bit
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_q1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            rx_q1 <= rx;
            rx_s  <= rx_q1;
        end
    end

    // Frame FSM: confirm start at mid-bit, then sample every full bit period
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            idx   <= '0;
            shreg <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (!rx_s) state <= S_START;
                end
                S_START: begin
                    if (cnt == CNT_HALF) begin
                        cnt   <= '0;
                        idx   <= '0;
                        state <= rx_s ? S_IDLE : S_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (cnt == CNT_FULL) begin
                        shreg[idx] <= rx_s;
                        cnt        <= '0;
                        if (idx == 3'd7) state <= S_STOP;
                        else             idx   <= idx + 3'd1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    // Leave at mid-stop so an immediately following start edge is seen
                    if (cnt == CNT_FULL) begin
                        cnt   <= '0;
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    // Bus decode, FIFO control and next-state of flags/count
    always_comb begin
        stop_tick = (state == S_STOP) && (cnt == CNT_FULL);
        push_req  = stop_tick && rx_s;
        ferr_set  = stop_tick && !rx_s;
        off       = addr[3:0];
        hit       = (addr[31:4] == BASE_ADDR[31:4]);
        rx_valid  = read_enable && hit;
        not_empty = (count != 5'd0);
        full      = (count == DEPTH_C);
        wr_ctrl   = write_enable && hit && (off == 4'h8);
        pop       = rx_valid && (off == 4'h0) && not_empty;
        flush     = wr_ctrl && write_data[3];
        do_push   = push_req && (!full || pop) && !flush;
        do_pop    = pop && !flush;
        ovr_set   = push_req && full && !pop;
        count_n   = flush ? 5'd0 : count + {4'd0, do_push} - {4'd0, do_pop};
        irq_en_n    = wr_ctrl ? write_data[2] : irq_en;
        overrun_n   = ovr_set  | (overrun   & ~(wr_ctrl & write_data[0]));
        frame_err_n = ferr_set | (frame_err & ~(wr_ctrl & write_data[1]));
    end

    // Register read mux; zero unless this is a load that hits the block
    always_comb begin
        read_data = 32'd0;
        if (rx_valid) begin
            case (off)
                4'h0:    read_data = {24'd0, not_empty ? mem[rd_ptr] : 8'h00};
                4'h4:    read_data = {23'd0, count, frame_err, overrun, full, not_empty};
                4'h8:    read_data = {29'd0, irq_en, frame_err, overrun};
                default: read_data = 32'd0;
            endcase
        end
    end

    // FIFO storage needs no reset; pointers and count define validity
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= shreg;
    end

    // FIFO pointers, sticky flags and registered interrupt
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= 5'd0;
            overrun      <= 1'b0;
            frame_err    <= 1'b0;
            irq_en       <= 1'b0;
            rx_interrupt <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (do_push) wr_ptr <= wr_ptr + 1'b1;
                if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            end
            count        <= count_n;
            overrun      <= overrun_n;
            frame_err    <= frame_err_n;
            irq_en       <= irq_en_n;
            rx_interrupt <= irq_en_n && (count_n != 5'd0);
        end
    end
endmodule

// File: doc/uart_rx.md
# uart_rx

Memory-mapped UART receiver that sits upstream of the CPU on the peripheral bus, alongside the timer and UART transmitter. It oversamples the asynchronous `rx` line and deserialises 8N1 frames, LSB first. Received bytes are buffered in a small FIFO, and the CPU drains them through load instructions. An optional level interrupt is raised while data is pending. Its bus port matches the timer/UART slave convention (`addr`, `write_data`, `write_enable`, `read_enable`, `read_data`, valid).

## Interface
- `CLK_FREQ`, 50_000_000: core clock in Hz.
- `BAUD_RATE`, 115200: line rate. `CLKS_PER_BIT = CLK_FREQ/BAUD_RATE`, integer division, must be ≥ 8.
- `FIFO_DEPTH`, 8: power of two, 2..16.
- `BASE_ADDR`, 32'h2000_0200: register block base. Decode requires `addr[31:4] == BASE_ADDR[31:4]`.
- Clocking: one clock; reset is synchronous and active-high.
- `clk`  in  1  core clock.
- `rst`  in  1  synchronous, active-high reset.
- `addr`  in  32  byte address from the CPU data port.
- `write_data`  in  32  store data.
- `write_enable`  in  1  store strobe, already qualified by the top-level decode.
- `read_enable`  in  1  load strobe, already qualified. It is high for exactly one cycle per load.
- `read_data`  out  32  combinational register read data.
- `rx_valid`  out  1  combinational; equals `read_enable` && address hit.
- `rx_interrupt`  out  1  registered level interrupt.
- `rx`  in  1  asynchronous serial input; idle level is high.

## Operation
- **Input synchroniser:** `rx` passes through 2 flops, both reset to 1. All logic below uses the synchronised signal.
- **Registers** (offsets from `BASE_ADDR`):
  - 0x0 RXDATA (R): `[7:0]` is the FIFO head byte and `[31:8]` are 0. A read with the FIFO non-empty pops the head. A read while empty returns 0 and has no side effect.
  - 0x4 STATUS (R): bit 0 not_empty, bit 1 full, bit 2 overrun (sticky), bit 3 frame_err (sticky), bits `[8:4]` occupancy count, all other bits 0.
  - 0x8 CTRL (R/W): bit 0 W1C overrun, bit 1 W1C frame_err, bit 2 irq_en (read/write), bit 3 flush (write-1 pulse, empties the FIFO, reads back 0). Other bits read as 0.
  - Any other offset reads 0. Writes to offsets 0x0 and 0x4 are ignored.
- **Receive FSM**, with baud counter `cnt` and bit index `idx[2:0]`:
  - IDLE: a low on the synchronised `rx` moves to START, with `cnt=0`.
  - START: at `cnt == CLKS_PER_BIT/2 - 1`, sample the line. If it is low, go to DATA with `cnt=0` and `idx=0`. If it is high, treat it as a glitch and return to IDLE with nothing recorded.
  - DATA: at `cnt == CLKS_PER_BIT-1`, sample into shift register bit `idx`, LSB first. After `idx == 7`, go to STOP.
  - STOP: at `cnt == CLKS_PER_BIT-1`, sample the line.
    - High: push the byte.
    - Low: set frame_err and discard the byte.
    - Either way, return to IDLE.
- **FIFO push:**
  - Push while full with no simultaneous pop: the byte is dropped and overrun is set.
  - Push and pop in the same cycle: both are performed and the count is unchanged, including when full.
- **Flush vs. push:** if flush and a push occur in the same cycle, flush wins and the FIFO ends empty.
- **Sticky flags:** if a set and a W1C clear of the same flag occur in the same cycle, the set wins.
- **Interrupt:** `rx_interrupt` is registered as `irq_en && not_empty`, evaluated on the next-state values.

## Timing
- **Reset values:**
  - FSM is IDLE; FIFO is empty; count = 0.
  - overrun = 0, frame_err = 0, irq_en = 0.
  - `rx_interrupt` = 0.
  - `read_data` = 0 and `rx_valid` = 0 while `read_enable` = 0.
- **Reset mid-frame:** aborts the frame. No partial byte is pushed.
- **Frame latency:** the falling edge on `rx` reaches the FSM 2 cycles later. The push happens at the STOP sample, about 9.5 bit-times after the start edge. not_empty is visible in STATUS the cycle after the push.
- **Reads:** `read_data` is valid in the same cycle as `read_enable`. The pop takes effect at that cycle's clock edge.
- **Interrupt timing:** `rx_interrupt` rises 1 cycle after the push that makes the FIFO non-empty (when irq_en = 1). It falls 1 cycle after the pop that empties the FIFO.
- **Back-to-back frames:** the FSM returns to IDLE at mid-stop-bit, so a start bit that immediately follows the stop bit is detected.

## Test plan
All scenarios use `CLK_FREQ=1_600_000` and `BAUD_RATE=100_000`, giving `CLKS_PER_BIT=16`.
- **Single byte:** send frame 0x55. STATUS reads 0x11. RXDATA reads 0x00000055 with `rx_valid` = 1. STATUS then reads 0x00.
- **Overflow:** send 9 frames, 0x00..0x08, with no reads. STATUS reads 0x87 (count 8, full, overrun). Eight RXDATA reads return 0x00..0x07. A ninth read returns 0. Writing CTRL = 0x1 clears overrun.
- **Glitch rejection:** drive `rx` low for 4 cycles, then high. No push, the FSM is back in IDLE, and STATUS stays 0x00. A following frame 0xC3 is received correctly.
- **Framing error:** send 0xA5 with the stop bit low. The FIFO stays empty and STATUS = 0x08. Writing CTRL = 0x2 returns STATUS to 0x00.
- **Interrupt:** write CTRL = 0x4, then send 0x3C. `rx_interrupt` is 1 one cycle after the push. Reading RXDATA (0x3C) drops it one cycle later. CTRL reads back 0x4.
- **Reset mid-frame:** assert `rst` for 1 cycle after 4 data bits. The FIFO is empty and nothing is pushed. A subsequent frame 0x81 reads back 0x81.
